// File: rtl/sync_pkg.sv
// -----------------------------------------------------------------------------
// sync_pkg
// Shared constants and helpers for the multi-stage synchroniser/filter.
//   SYNC_MIN_STAGES / SYNC_MAX_STAGES : legal synchroniser depth range.
//   filt_cnt_width(f)                 : width of a stability counter that must
//                                       hold 0..f, never narrower than 1 bit.
// -----------------------------------------------------------------------------
package sync_pkg;

  localparam int SYNC_MIN_STAGES = 2;
  localparam int SYNC_MAX_STAGES = 4;

  function automatic int filt_cnt_width(input int f);
    return (f < 1) ? 1 : $clog2(f + 1);
  endfunction

endpackage

// File: rtl/multisync_filter_bit.sv
// -----------------------------------------------------------------------------
// multisync_filter_bit
// One channel of multisync_filter: STAGES-deep synchroniser chain, optional
// stability filter, and the registered change (and edge) pulses.
//
// Optional feature macro: MULTISYNC_EDGE_DETECT_EN (adds rise_o / fall_o).
//
// Ports:
//   clk        in   destination-domain clock
//   reset      in   synchronous, active-low reset
//   in_i       in   asynchronous input bit
//   out_o      out  synchronised, filtered level (registered)
//   change_o   out  one-cycle pulse in the cycle out_o changed
//   settling_o out  stability counter is non-zero
//   rise_o     out  out_o went 0->1 this cycle   (MULTISYNC_EDGE_DETECT_EN)
//   fall_o     out  out_o went 1->0 this cycle   (MULTISYNC_EDGE_DETECT_EN)
// -----------------------------------------------------------------------------
module multisync_filter_bit
  import sync_pkg::*;
#(
  parameter int   STAGES        = 2,
  parameter int   FILTER_CYCLES = 0,
  parameter logic RESET_VALUE   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic in_i,
  output logic out_o,
  output logic change_o,
  output logic settling_o
`ifdef MULTISYNC_EDGE_DETECT_EN
  ,
  output logic rise_o,
  output logic fall_o
`endif
);

  // Synchroniser chain: pure flop-to-flop, nothing between stages.
  logic [STAGES-1:0] sync_q;
  logic              sync_s;
  // Level out_o will take at the next edge (ignoring reset).
  logic              out_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q <= {STAGES{RESET_VALUE}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], in_i};
    end
  end

  assign sync_s = sync_q[STAGES-1];

  if (FILTER_CYCLES == 0) begin : g_bypass
    // The last sync stage is already a flop, so it is the output register.
    assign out_o      = sync_s;
    assign out_d      = sync_q[STAGES-2];
    assign settling_o = 1'b0;
  end else begin : g_filter
    localparam int              CW       = filt_cnt_width(FILTER_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(FILTER_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          out_q;

    // NOTE: every always_comb output gets a default first, so no path leaves
    // a variable unassigned and no latch is inferred.
    always_comb begin
      cnt_d = '0;
      out_d = out_q;
      if (sync_s != out_q) begin
        if (cnt_q == CNT_LAST) begin
          out_d = sync_s;             // stable long enough: follow, restart count
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end

    always_ff @(posedge clk) begin
      if (!reset) begin
        cnt_q <= '0;
        out_q <= RESET_VALUE;
      end else begin
        cnt_q <= cnt_d;
        out_q <= out_d;
      end
    end

    assign out_o      = out_q;
    assign settling_o = (cnt_q != '0);
  end

  // Change/edge pulses are registered against the same edge that updates
  // out_o, so they are high exactly while the new level is first visible.
  logic change_q;

`ifdef MULTISYNC_EDGE_DETECT_EN
  logic rise_q, fall_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      change_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      change_q <= out_d ^ out_o;
      rise_q   <= out_d & ~out_o;
      fall_q   <= ~out_d & out_o;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;
`else
  always_ff @(posedge clk) begin
    if (!reset) begin
      change_q <= 1'b0;
    end else begin
      change_q <= out_d ^ out_o;
    end
  end
`endif

  assign change_o = change_q;

endmodule

// File: rtl/multisync_filter.sv
// -----------------------------------------------------------------------------
// multisync_filter
// WIDTH independent channels, each a STAGES-deep synchroniser followed by an
// optional stability filter requiring FILTER_CYCLES consecutive stable cycles
// (0 = bypass). Lives entirely in the destination clock domain.
//
// Optional feature macro: MULTISYNC_EDGE_DETECT_EN (adds rise / fall ports).
//
// Ports:
//   clk       in   [1]      destination-domain clock
//   reset     in   [1]      synchronous, active-low reset
//   indata    in   [WIDTH]  asynchronous inputs
//   outdata   out  [WIDTH]  synchronised, filtered levels (registered)
//   update    out  [1]      one-cycle pulse when any outdata bit changed
//   settling  out  [1]      any channel's filter counter is non-zero
//   rise      out  [WIDTH]  per-bit 0->1 pulse of outdata (MULTISYNC_EDGE_DETECT_EN)
//   fall      out  [WIDTH]  per-bit 1->0 pulse of outdata (MULTISYNC_EDGE_DETECT_EN)
// -----------------------------------------------------------------------------
module multisync_filter
  import sync_pkg::*;
#(
  parameter int               WIDTH         = 1,
  parameter int               STAGES        = 2,
  parameter int               FILTER_CYCLES = 0,
  parameter logic [WIDTH-1:0] RESET_VALUE   = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] indata,
  output logic [WIDTH-1:0] outdata,
  output logic             update,
  output logic             settling
`ifdef MULTISYNC_EDGE_DETECT_EN
  ,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
`endif
);

  if (STAGES < SYNC_MIN_STAGES || STAGES > SYNC_MAX_STAGES) begin : g_stage_check
    $error("multisync_filter: STAGES=%0d outside legal range %0d..%0d",
           STAGES, SYNC_MIN_STAGES, SYNC_MAX_STAGES);
  end

  logic [WIDTH-1:0] change_vec;
  logic [WIDTH-1:0] settling_vec;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    multisync_filter_bit #(
      .STAGES        (STAGES),
      .FILTER_CYCLES (FILTER_CYCLES),
      .RESET_VALUE   (RESET_VALUE[i])
    ) u_bit (
      .clk        (clk),
      .reset      (reset),
      .in_i       (indata[i]),
      .out_o      (outdata[i]),
      .change_o   (change_vec[i]),
      .settling_o (settling_vec[i])
`ifdef MULTISYNC_EDGE_DETECT_EN
      ,
      .rise_o     (rise[i]),
      .fall_o     (fall[i])
`endif
    );
  end

  // Per-bit pulses are all aligned to the same edge, so simultaneous changes
  // merge into one single-cycle update pulse.
  assign update   = |change_vec;
  assign settling = |settling_vec;

endmodule

// File: tb/tb_multisync_filter.sv
// -----------------------------------------------------------------------------
// tb_multisync_filter
// Three configurations driven from one shared 8-bit stimulus:
//   dut_a : WIDTH=8, STAGES=2, F=0 (bypass), RESET_VALUE=8'h00
//   dut_b : WIDTH=1, STAGES=3, F=4,          RESET_VALUE=1'b0
//   dut_c : WIDTH=4, STAGES=4, F=2,          RESET_VALUE=4'b1010
// The reference model keeps the full history of sampled inputs and reset and
// derives each output from the behavioural rules: s is the input captured
// STAGES-1 edges ago unless a reset intervened; a filtered output flips once
// the last F evaluations (all outside reset) saw s differ from it.
// -----------------------------------------------------------------------------
module tb_multisync_filter;

  localparam int NCYC = 1000;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] indata;

  logic [7:0] out_a;
  logic       upd_a, set_a;
  logic [0:0] out_b;
  logic       upd_b, set_b;
  logic [3:0] out_c;
  logic       upd_c, set_c;
`ifdef MULTISYNC_EDGE_DETECT_EN
  logic [7:0] rise_a, fall_a;
  logic [0:0] rise_b, fall_b;
  logic [3:0] rise_c, fall_c;
`endif

  always #5 clk = ~clk;

  multisync_filter #(.WIDTH(8), .STAGES(2), .FILTER_CYCLES(0), .RESET_VALUE(8'h00)) dut_a (
    .clk(clk), .reset(reset), .indata(indata), .outdata(out_a),
    .update(upd_a), .settling(set_a)
`ifdef MULTISYNC_EDGE_DETECT_EN
    , .rise(rise_a), .fall(fall_a)
`endif
  );

  multisync_filter #(.WIDTH(1), .STAGES(3), .FILTER_CYCLES(4), .RESET_VALUE(1'b0)) dut_b (
    .clk(clk), .reset(reset), .indata(indata[0:0]), .outdata(out_b),
    .update(upd_b), .settling(set_b)
`ifdef MULTISYNC_EDGE_DETECT_EN
    , .rise(rise_b), .fall(fall_b)
`endif
  );

  multisync_filter #(.WIDTH(4), .STAGES(4), .FILTER_CYCLES(2), .RESET_VALUE(4'b1010)) dut_c (
    .clk(clk), .reset(reset), .indata(indata[3:0]), .outdata(out_c),
    .update(upd_c), .settling(set_c)
`ifdef MULTISYNC_EDGE_DETECT_EN
    , .rise(rise_c), .fall(fall_c)
`endif
  );

  // History: index = edge number (1 = first edge). Entry 0 is "before time".
  logic [7:0] in_hist  [0:NCYC];
  bit         rst_hist [0:NCYC];
  logic [7:0] eo_a     [0:NCYC];
  logic [7:0] eo_b     [0:NCYC];
  logic [7:0] eo_c     [0:NCYC];

  int n      = 0;
  int n_cmp  = 0;
  int n_err  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", tag, n, got, exp);
    end
  endtask

  // Value at the end of the sync chain just after edge e.
  function automatic logic [7:0] s_val(input int e, input int stg, input logic [7:0] rv);
    if (e - stg + 1 < 1) return rv;
    for (int k = e - stg + 1; k <= e; k++) begin
      if (rst_hist[k]) return rv;
    end
    return in_hist[e - stg + 1];
  endfunction

  // Expected outdata and settling just after edge e, given outdata before it.
  task automatic model_step(input int e, input int stg, input int f, input logic [7:0] rv,
                            input int w, input logic [7:0] prev,
                            output logic [7:0] nout, output logic settle);
    logic [7:0] sv;
    bit         accept, go;
    int         run;
    nout   = prev;
    settle = 1'b0;
    if (rst_hist[e]) begin
      nout = rv;
    end else begin
      for (int i = 0; i < w; i++) begin
        if (f == 0) begin
          sv      = s_val(e, stg, rv);
          nout[i] = sv[i];
        end else begin
          // Flip only if the last f evaluations all saw s differ from out.
          accept = 1'b1;
          for (int j = 1; j <= f; j++) begin
            if (e - j + 1 < 1) accept = 1'b0;
            else if (rst_hist[e - j + 1]) accept = 1'b0;
            else begin
              sv = s_val(e - j, stg, rv);
              if (sv[i] == prev[i]) accept = 1'b0;
            end
          end
          if (accept) nout[i] = ~prev[i];
          // Pending run length against the (possibly new) level.
          run = 0;
          go  = 1'b1;
          for (int j = 1; j <= f; j++) begin
            if (go) begin
              if (e - j + 1 < 1) go = 1'b0;
              else if (rst_hist[e - j + 1]) go = 1'b0;
              else begin
                sv = s_val(e - j, stg, rv);
                if (sv[i] == nout[i]) go = 1'b0;
                else run++;
              end
            end
          end
          if (run != 0) settle = 1'b1;
        end
      end
    end
  endtask

  task automatic run_cycle(input logic [7:0] din, input logic rn);
    logic [7:0] o;
    logic       st;
    logic       r;
    indata = din;
    reset  = rn;
    @(posedge clk);
    n++;
    if (n > NCYC) begin
      $display("FAIL cycle_budget: got %0d expected at most %0d", n, NCYC);
      $fatal(1, "cycle budget exceeded");
    end
    in_hist[n]  = indata;
    rst_hist[n] = !reset;
    r           = rst_hist[n];
    #1;

    model_step(n, 2, 0, 8'h00, 8, eo_a[n-1], o, st);
    eo_a[n] = o;
    check("a_out", 32'(out_a), 32'(o));
    check("a_upd", 32'(upd_a), 32'(!r && (o != eo_a[n-1])));
    check("a_set", 32'(set_a), 32'(st));

    model_step(n, 3, 4, 8'h00, 1, eo_b[n-1], o, st);
    eo_b[n] = o;
    check("b_out", 32'(out_b), 32'(o[0]));
    check("b_upd", 32'(upd_b), 32'(!r && (o != eo_b[n-1])));
    check("b_set", 32'(set_b), 32'(st));

    model_step(n, 4, 2, 8'h0A, 4, eo_c[n-1], o, st);
    eo_c[n] = o;
    check("c_out", 32'(out_c), 32'(o[3:0]));
    check("c_upd", 32'(upd_c), 32'(!r && (o != eo_c[n-1])));
    check("c_set", 32'(set_c), 32'(st));

`ifdef MULTISYNC_EDGE_DETECT_EN
    check("a_rise", 32'(rise_a), r ? 32'd0 : 32'(eo_a[n] & ~eo_a[n-1]));
    check("a_fall", 32'(fall_a), r ? 32'd0 : 32'(~eo_a[n] & eo_a[n-1]));
    check("b_rise", 32'(rise_b), r ? 32'd0 : 32'(eo_b[n][0] & ~eo_b[n-1][0]));
    check("b_fall", 32'(fall_b), r ? 32'd0 : 32'(~eo_b[n][0] & eo_b[n-1][0]));
    check("c_rise", 32'(rise_c), r ? 32'd0 : 32'(eo_c[n][3:0] & ~eo_c[n-1][3:0]));
    check("c_fall", 32'(fall_c), r ? 32'd0 : 32'(~eo_c[n][3:0] & eo_c[n-1][3:0]));
`endif
  endtask

  initial begin
    logic [7:0] din;
    in_hist[0]  = 8'h00;
    rst_hist[0] = 1'b1;
    eo_a[0]     = 8'h00;
    eo_b[0]     = 8'h00;
    eo_c[0]     = 8'h0A;

    // Reset held with all inputs high: outputs must sit at RESET_VALUE.
    repeat (4) run_cycle(8'hFF, 1'b0);
    repeat (6) run_cycle(8'h00, 1'b1);

    // Step to F1: bypass follows after STAGES-1 edges, bit0 held for dut_b.
    repeat (12) run_cycle(8'hF1, 1'b1);
    repeat (12) run_cycle(8'hF0, 1'b1);

    // Pulse of 3 cycles on bit0: shorter than F=4, must be rejected by dut_b.
    repeat (3) run_cycle(8'hF1, 1'b1);
    repeat (10) run_cycle(8'hF0, 1'b1);

    // Reset while dut_b is counting, then a full-latency step afterwards.
    repeat (5) run_cycle(8'h01, 1'b1);
    run_cycle(8'h01, 1'b0);
    repeat (12) run_cycle(8'h01, 1'b1);

    // Simultaneous rise and fall on different bits.
    repeat (10) run_cycle(8'h03, 1'b1);
    repeat (10) run_cycle(8'h05, 1'b1);

    // Random phase: sparse bit flips so filters both reject and accept,
    // with occasional resets.
    din = 8'h05;
    repeat (800) begin
      if ($urandom_range(3) == 0) din = din ^ 8'($urandom & $urandom);
      if ($urandom_range(9) == 0) din = din ^ (8'h01 << $urandom_range(7));
      run_cycle(din, ($urandom_range(79) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multisync_filter.md
Name: multisync_filter

Overview:
- Parametrised successor to the two-flop synchroniser, living in the destination clock domain (e.g. 12 MHz audio clock).
- Provides a configurable-depth synchroniser chain per bit, then a per-bit stability (glitch) filter.
- The filter output and its change indication feed control logic that needs clean, debounced, domain-safe levels: mode bits, key/switch inputs, cross-domain flags.

Parameters:
- WIDTH, 1, number of independent 1-bit channels.
- STAGES, 2, synchroniser flops per channel; legal range 2..4.
- FILTER_CYCLES, 0, consecutive stable cycles required before the output follows; 0 = filter bypassed.
- RESET_VALUE, '0, WIDTH-bit value loaded into every sync stage and outdata at reset.

Ports:
- clk  in  1  destination-domain clock.
- reset  in  1  synchronous, active-low reset.
- indata  in  WIDTH  asynchronous inputs; no timing relation to clk.
- outdata  out  WIDTH  synchronised, filtered levels; registered.
- update  out  1  one-cycle pulse in the same cycle any outdata bit changes.
- settling  out  1  high while any channel's filter counter is non-zero.

Behaviour:
- Reset (reset==0 at posedge clk):
  - all sync stages and outdata = RESET_VALUE;
  - all counters = 0; update = 0; settling = 0.
  - In-flight values are discarded.
  - First capture happens at the first edge with reset==1.
- Sync chain per bit: stage[0] <= indata[i]; stage[j] <= stage[j-1]. Let s = stage[STAGES-1]. No logic is allowed between stages.
- FILTER_CYCLES==0:
  - outdata[i] = s directly; no counter logic is generated; settling is tied to 0.
  - Latency: a value stable at edge k appears on outdata after edge k+STAGES-1. STAGES=2 is cycle-equivalent to the existing doublesync.
- FILTER_CYCLES=F>=1, per-bit counter of width $clog2(F+1), evaluated each edge:
  - s==outdata[i]: cnt <= 0.
  - s!=outdata[i] and cnt<F-1: cnt <= cnt+1.
  - s!=outdata[i] and cnt==F-1: outdata[i] <= s; cnt <= 0.
  - Total latency from the first capture edge is STAGES+F-1 edges for a clean step.
  - A pulse shorter than F cycles at s never reaches outdata. The counter restarts from 0 on any return to the current level.
- update is registered: high in exactly the cycles where outdata differs from its previous value.
  - Simultaneous changes on several bits produce one single-cycle pulse.
  - Never asserted in the cycle reset is applied or the first cycle after.
- settling = OR of (cnt!=0) across channels, registered alongside the counters.
- Reset asserted mid-filter: counter cleared and outdata forced to RESET_VALUE in that same edge; the pending change is lost.
- Counters never wrap. Maximum value is F-1.
- Parameter check: STAGES<2 or STAGES>4 causes an elaboration $error.

Optional Feature:
- Macro MULTISYNC_EDGE_DETECT_EN.
- Defined: adds ports rise (out, WIDTH) and fall (out, WIDTH).
  - Registered one-cycle pulses, high in the same cycle outdata[i] transitions 0->1 (rise) or 1->0 (fall).
  - Both are 0 at reset and in the cycle after reset.
  - Both are derived from outdata, so the filter applies to them.
- Undefined: the ports and their flops do not exist. All other behaviour is identical.

Decomposition:
- Package sync_pkg:
  - constants SYNC_MIN_STAGES=2, SYNC_MAX_STAGES=4;
  - function filt_cnt_width(F) returning $clog2(F+1) with a minimum of 1.
- Sub-module multisync_filter_bit: one channel (sync chain, counter, output flop, optional edge flops), instantiated WIDTH times via generate.
- The top level ORs the per-bit change and settling signals into update and settling.

Test Plan:
- Reset: reset=0 with indata=8'hFF, WIDTH=8, RESET_VALUE=8'h00 -> outdata=8'h00, update=0, settling=0 for all reset cycles.
- Bypass: WIDTH=8, STAGES=2, F=0; indata 8'h00->8'hF1 one cycle before edge k -> outdata=8'hF1 after edge k+1, update pulse exactly 1 cycle.
- Filter reject: WIDTH=1, STAGES=3, F=4; indata 0->1 for 3 clk cycles then back to 0 -> outdata stays 0, update never asserts, settling high 3 cycles then 0.
- Filter accept: same configuration, indata 0->1 held -> outdata rises exactly STAGES+F-1=6 edges after the first capture edge, update=1 for 1 cycle.
- Reset mid-filter: F=4, assert reset when cnt==2 -> cnt=0 and outdata=RESET_VALUE next edge; after release, full 6-edge latency is required again.
- Edge detect (MULTISYNC_EDGE_DETECT_EN): WIDTH=4, 4'b0011->4'b0101 -> rise=4'b0100 and fall=4'b0010 for one cycle, coincident with update.
